// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// One op at a time: 32-cycle shift-add multiply or restoring divide, with
// divide-by-zero and signed-overflow cases resolved in a single cycle.
// stall_req freezes the front of the pipeline until the result is ready.
module ex_muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      regdest_in,
  output logic            busy,
  output logic            stall_req,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      regdest_out
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t              state_r, state_nxt_s;
  logic [2:0]          funct3_r;
  logic [4:0]          rd_r;
  logic                neg_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [2*XLEN-1:0]   acc_r, mcand_r;
  logic [XLEN-1:0]     mplier_r, rem_r, quo_r, divisor_r;
  logic [XLEN-1:0]     result_r;
  logic [4:0]          regdest_out_r;

  logic                accept_s, last_s;
  logic                a_sgn_s, b_sgn_s, neg_s, special_s;
  logic [XLEN-1:0]     abs_a_s, abs_b_s, special_res_s;
  logic [2*XLEN-1:0]   mul_acc_nxt_s, prod_s;
  logic [XLEN:0]       div_shift_s, div_diff_s;
  logic [XLEN-1:0]     div_rem_nxt_s, div_quo_nxt_s, quo_s, rem_s, fin_res_s;

  assign accept_s = (state_r == ST_IDLE) && start && !flush;
  assign last_s   = (cnt_r == CNT_W'(XLEN - 1));

  // Operand preparation at accept: sign handling, magnitudes and special cases.
  always_comb begin
    a_sgn_s       = 1'b0;
    b_sgn_s       = 1'b0;
    neg_s         = 1'b0;
    special_s     = 1'b0;
    special_res_s = {XLEN{1'b0}};
    case (funct3)
      3'b001:  begin a_sgn_s = op_a[XLEN-1]; b_sgn_s = op_b[XLEN-1]; neg_s = a_sgn_s ^ b_sgn_s; end
      3'b010:  begin a_sgn_s = op_a[XLEN-1]; neg_s = a_sgn_s; end
      3'b100:  begin a_sgn_s = op_a[XLEN-1]; b_sgn_s = op_b[XLEN-1]; neg_s = a_sgn_s ^ b_sgn_s; end
      3'b110:  begin a_sgn_s = op_a[XLEN-1]; b_sgn_s = op_b[XLEN-1]; neg_s = a_sgn_s; end
      default: begin a_sgn_s = 1'b0; b_sgn_s = 1'b0; neg_s = 1'b0; end
    endcase
    abs_a_s = a_sgn_s ? (~op_a + 32'd1) : op_a;
    abs_b_s = b_sgn_s ? (~op_b + 32'd1) : op_b;
    if (funct3[2] && (op_b == 32'd0)) begin
      special_s     = 1'b1;
      special_res_s = funct3[1] ? op_a : 32'hFFFF_FFFF;
    end else if (funct3[2] && !funct3[0] && (op_a == 32'h8000_0000) && (op_b == 32'hFFFF_FFFF)) begin
      special_s     = 1'b1;
      special_res_s = funct3[1] ? 32'd0 : 32'h8000_0000;
    end else begin
      special_s     = 1'b0;
      special_res_s = {XLEN{1'b0}};
    end
  end

  // One iteration step of both datapaths plus the final sign-corrected result.
  always_comb begin
    mul_acc_nxt_s = acc_r + (mplier_r[0] ? mcand_r : 64'd0);
    div_shift_s   = {rem_r, quo_r[XLEN-1]};
    div_diff_s    = div_shift_s - {1'b0, divisor_r};
    if (div_shift_s >= {1'b0, divisor_r}) begin
      div_rem_nxt_s = div_diff_s[XLEN-1:0];
      div_quo_nxt_s = {quo_r[XLEN-2:0], 1'b1};
    end else begin
      div_rem_nxt_s = div_shift_s[XLEN-1:0];
      div_quo_nxt_s = {quo_r[XLEN-2:0], 1'b0};
    end
    prod_s = neg_r ? (64'd0 - mul_acc_nxt_s) : mul_acc_nxt_s;
    quo_s  = neg_r ? (32'd0 - div_quo_nxt_s) : div_quo_nxt_s;
    rem_s  = neg_r ? (32'd0 - div_rem_nxt_s) : div_rem_nxt_s;
    case (funct3_r)
      3'b000:  fin_res_s = prod_s[XLEN-1:0];
      3'b001,
      3'b010,
      3'b011:  fin_res_s = prod_s[2*XLEN-1:XLEN];
      3'b100,
      3'b101:  fin_res_s = quo_s;
      3'b110,
      3'b111:  fin_res_s = rem_s;
      default: fin_res_s = {XLEN{1'b0}};
    endcase
  end

  // Next-state logic; flush always returns to IDLE and beats start.
  always_comb begin
    state_nxt_s = state_r;
    if (flush) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            if (!funct3[2])     state_nxt_s = ST_MUL;
            else if (special_s) state_nxt_s = ST_DONE;
            else                state_nxt_s = ST_DIV;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_MUL:  state_nxt_s = last_s ? ST_DONE : ST_MUL;
        ST_DIV:  state_nxt_s = last_s ? ST_DONE : ST_DIV;
        ST_DONE: state_nxt_s = ST_IDLE;
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // State, operand/datapath registers and the registered result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      funct3_r      <= 3'd0;
      rd_r          <= 5'd0;
      neg_r         <= 1'b0;
      cnt_r         <= {CNT_W{1'b0}};
      acc_r         <= 64'd0;
      mcand_r       <= 64'd0;
      mplier_r      <= 32'd0;
      rem_r         <= 32'd0;
      quo_r         <= 32'd0;
      divisor_r     <= 32'd0;
      result_r      <= 32'd0;
      regdest_out_r <= 5'd0;
    end else begin
      state_r <= state_nxt_s;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            funct3_r  <= funct3;
            rd_r      <= regdest_in;
            neg_r     <= neg_s;
            cnt_r     <= {CNT_W{1'b0}};
            acc_r     <= 64'd0;
            mcand_r   <= {32'd0, abs_a_s};
            mplier_r  <= abs_b_s;
            rem_r     <= 32'd0;
            quo_r     <= abs_a_s;
            divisor_r <= abs_b_s;
            if (special_s) begin
              result_r      <= special_res_s;
              regdest_out_r <= regdest_in;
            end
          end
        end
        ST_MUL: begin
          acc_r    <= mul_acc_nxt_s;
          mcand_r  <= {mcand_r[2*XLEN-2:0], 1'b0};
          mplier_r <= {1'b0, mplier_r[XLEN-1:1]};
          cnt_r    <= cnt_r + CNT_W'(1);
          if (last_s && !flush) begin
            result_r      <= fin_res_s;
            regdest_out_r <= rd_r;
          end
        end
        ST_DIV: begin
          rem_r <= div_rem_nxt_s;
          quo_r <= div_quo_nxt_s;
          cnt_r <= cnt_r + CNT_W'(1);
          if (last_s && !flush) begin
            result_r      <= fin_res_s;
            regdest_out_r <= rd_r;
          end
        end
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  assign busy        = (state_r != ST_IDLE);
  assign done        = (state_r == ST_DONE);
  assign stall_req   = accept_s || (state_r == ST_MUL) || (state_r == ST_DIV);
  assign result      = result_r;
  assign regdest_out = regdest_out_r;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed cases plus random ops
// compared against an arithmetic reference model.
module tb_ex_muldiv_unit;

  logic        clk, reset, flush, start;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b;
  logic [4:0]  regdest_in;
  logic        busy, stall_req, done;
  logic [31:0] result;
  logic [4:0]  regdest_out;

  int checks = 0;
  int errors = 0;

  ex_muldiv_unit dut (
    .clk(clk), .reset(reset), .flush(flush), .start(start),
    .funct3(funct3), .op_a(op_a), .op_b(op_b), .regdest_in(regdest_in),
    .busy(busy), .stall_req(stall_req), .done(done),
    .result(result), .regdest_out(regdest_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  // RV32M semantics computed with plain 64-bit / integer arithmetic.
  function automatic logic [31:0] model_result(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, p;
    logic [63:0] ua, ub, up;
    int ia, ib;
    logic ovf;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    ia = a;
    ib = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'b000: begin p = sa * sb; return p[31:0]; end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * $signed(ub); return p[63:32]; end
      3'b011: begin up = ua * ub; return up[63:32]; end
      3'b100: return (b == 0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : 32'(ia / ib));
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: return (b == 0) ? a : (ovf ? 32'd0 : 32'(ia % ib));
      3'b111: return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    int n;
    int exp_lat;
    logic stall_ok;
    logic [31:0] exp;
    exp = model_result(f, a, b);
    exp_lat = (f[2] && ((b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) ? 1 : 33;
    @(negedge clk);
    funct3 = f; op_a = a; op_b = b; regdest_in = rd; start = 1'b1;
    #1;
    check_eq("stall_at_start", 64'(stall_req), 64'd1);
    n = 0;
    stall_ok = 1'b1;
    while (n < 40) begin
      @(negedge clk);
      start = 1'b0;
      n++;
      if (done) break;
      if (!stall_req || !busy) stall_ok = 1'b0;
    end
    check_eq("latency", 64'(n), 64'(exp_lat));
    check_eq("result", 64'(result), 64'(exp));
    check_eq("regdest", 64'(regdest_out), 64'(rd));
    check_eq("stall_in_done", 64'(stall_req), 64'd0);
    check_eq("stall_during_op", 64'(stall_ok), 64'd1);
    @(negedge clk);
    check_eq("idle_after_done", 64'({busy, done}), 64'd0);
    check_eq("result_held", 64'(result), 64'(exp));
  endtask

  initial begin
    int ndone;
    logic [31:0] prev_res;
    logic [2:0] rf;
    logic [31:0] ra, rb;
    reset = 1'b1; flush = 1'b0; start = 1'b0;
    funct3 = 3'd0; op_a = 32'd0; op_b = 32'd0; regdest_in = 5'd0;
    repeat (2) @(negedge clk);
    check_eq("reset_outputs", 64'({busy, stall_req, done, result, regdest_out}), 64'd0);
    reset = 1'b0;

    // Directed cases.
    run_op(3'b000, 32'd7, 32'd6, 5'd9);
    run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1);
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
    run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd4);
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd5);
    run_op(3'b101, 32'd100, 32'd7, 5'd6);
    run_op(3'b111, 32'd100, 32'd7, 5'd7);
    run_op(3'b101, 32'd5, 32'd0, 5'd8);
    run_op(3'b111, 32'd5, 32'd0, 5'd10);
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11);
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12);

    // Flush in the middle of a divide.
    prev_res = model_result(3'b110, 32'h8000_0000, 32'hFFFF_FFFF);
    @(negedge clk);
    funct3 = 3'b100; op_a = 32'd1000; op_b = 32'd7; regdest_in = 5'd13; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) ndone++;
    end
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check_eq("flush_idle", 64'({busy, stall_req, done}), 64'd0);
    check_eq("flush_no_done", 64'(ndone), 64'd0);
    check_eq("flush_result_held", 64'(result), 64'(prev_res));
    check_eq("flush_regdest_held", 64'(regdest_out), 64'd12);
    run_op(3'b000, 32'd3, 32'd5, 5'd14);

    // Reset in the middle of a multiply.
    @(negedge clk);
    funct3 = 3'b000; op_a = 32'd123; op_b = 32'd456; regdest_in = 5'd15; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("reset_mid_op", 64'({busy, stall_req, done, result, regdest_out}), 64'd0);

    // Start together with flush is dropped.
    @(negedge clk);
    funct3 = 3'b000; op_a = 32'd2; op_b = 32'd2; regdest_in = 5'd16; start = 1'b1; flush = 1'b1;
    #1;
    check_eq("flush_start_stall", 64'(stall_req), 64'd0);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check_eq("flush_start_idle", 64'(busy), 64'd0);
    ndone = 0;
    repeat (36) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check_eq("flush_start_no_done", 64'(ndone), 64'd0);

    // Randomized ops, biased toward the corner operands.
    for (int i = 0; i < 60; i++) begin
      rf = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: begin ra = 32'($urandom_range(0, 300)); rb = 32'($urandom_range(1, 20)); end
        3: rb = 32'd0 - 32'($urandom_range(1, 20));
        default: ra = ra;
      endcase
      run_op(rf, ra, rb, 5'($urandom_range(0, 31)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
